// File: rtl/draw_pkg.sv
// Shared types and helpers for the sprite batch draw engine.
package draw_pkg;

   // Default sprite geometry, used as parameter defaults by the engine.
   localparam int DEF_SPR_W_LOG2 = 4;
   localparam int DEF_SPR_H_LOG2 = 4;
   localparam int DEF_KIND_W     = 2;

   // Pixels per sprite and ROM address width for the default geometry.
   localparam int SPR_PIX = 1 << (DEF_SPR_W_LOG2 + DEF_SPR_H_LOG2);
   localparam int ROM_AW  = DEF_KIND_W + DEF_SPR_H_LOG2 + DEF_SPR_W_LOG2;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      LOAD,
      DRAW,
      FLUSH,
      DONE
   } state_t;

   // Ceiling log2, usable in constant expressions.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sprite_pixel_counter.sv
// Row/column walker over one sprite, row-major, with a last-pixel flag.
module sprite_pixel_counter
   import draw_pkg::*;
#(
   parameter int SPR_W_LOG2 = DEF_SPR_W_LOG2,
   parameter int SPR_H_LOG2 = DEF_SPR_H_LOG2
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  clr,
   input  logic                  en,
   output logic [SPR_H_LOG2-1:0] row,
   output logic [SPR_W_LOG2-1:0] col,
   output logic                  last
);

   localparam int IDX_W = SPR_W_LOG2 + SPR_H_LOG2;

   // Linear pixel index; column is the low field so it wraps into the row.
   logic [IDX_W-1:0] idx;

   // Pixel index register: clear wins over enable.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         idx <= '0;
      end else if (clr) begin
         idx <= '0;
      end else if (en) begin
         idx <= idx + IDX_W'(1);
      end
   end

   assign row  = idx[IDX_W-1:SPR_W_LOG2];
   assign col  = idx[SPR_W_LOG2-1:0];
   assign last = &idx;

endmodule

// File: rtl/sprite_batch_draw_engine.sv
// Draws every valid slot of the object table into the frame-buffer write port,
// one sprite pixel per cycle, clipping off-screen and transparent pixels.
module sprite_batch_draw_engine
   import draw_pkg::*;
#(
   parameter int                 N_OBJ        = 8,
   parameter int                 X_W          = 9,
   parameter int                 Y_W          = 8,
   parameter int                 SCREEN_W     = 320,
   parameter int                 SCREEN_H     = 240,
   parameter int                 SPR_W_LOG2   = DEF_SPR_W_LOG2,
   parameter int                 SPR_H_LOG2   = DEF_SPR_H_LOG2,
   parameter int                 KIND_W       = DEF_KIND_W,
   parameter int                 COLOR_W      = 3,
   parameter bit                 TRANSP_EN    = 1'b1,
   parameter logic [COLOR_W-1:0] TRANSP_COLOR = '0
) (
   input  logic                                  clk,
   input  logic                                  resetn,
   input  logic                                  start,
   input  logic [N_OBJ-1:0]                      obj_valid,
   input  logic [N_OBJ*X_W-1:0]                  obj_x,
   input  logic [N_OBJ*Y_W-1:0]                  obj_y,
   input  logic [N_OBJ*KIND_W-1:0]               obj_kind,
   output logic [KIND_W+SPR_H_LOG2+SPR_W_LOG2-1:0] rom_addr,
   input  logic [COLOR_W-1:0]                    rom_data,
   output logic [X_W-1:0]                        vga_x,
   output logic [Y_W-1:0]                        vga_y,
   output logic [COLOR_W-1:0]                    vga_colour,
   output logic                                  vga_write,
   output logic                                  busy,
   output logic                                  done,
   output logic [clog2(N_OBJ+1)-1:0]             objs_drawn
);

   localparam int                SLOT_W    = (N_OBJ > 1) ? clog2(N_OBJ) : 1;
   localparam int                CNT_W     = clog2(N_OBJ + 1);
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_OBJ - 1);
   localparam logic [X_W:0]      X_LIM     = (X_W + 1)'(SCREEN_W);
   localparam logic [Y_W:0]      Y_LIM     = (Y_W + 1)'(SCREEN_H);

   state_t state, next_state;

   logic [SLOT_W-1:0]     slot;
   logic [X_W-1:0]        x_q;
   logic [Y_W-1:0]        y_q;
   logic [KIND_W-1:0]     kind_q;
   logic [X_W:0]          px;      // one extra bit so wrap-around is clipped
   logic [Y_W:0]          py;
   logic                  p_valid;
   logic [SPR_H_LOG2-1:0] row;
   logic [SPR_W_LOG2-1:0] col;
   logic                  last_pix;
   logic                  last_slot;

   assign last_slot = (slot == LAST_SLOT);

   sprite_pixel_counter #(
      .SPR_W_LOG2 (SPR_W_LOG2),
      .SPR_H_LOG2 (SPR_H_LOG2)
   ) u_counter (
      .clk    (clk),
      .resetn (resetn),
      .clr    (state == LOAD),
      .en     (state == DRAW),
      .row    (row),
      .col    (col),
      .last   (last_pix)
   );

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= next_state;
   end

   // Next-state decode and status outputs.
   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      next_state = state;
      busy       = (state != IDLE);
      done       = (state == DONE);
      case (state)
         IDLE:    if (start) next_state = SCAN;
         SCAN: begin
            if (obj_valid[slot]) next_state = LOAD;
            else if (last_slot)  next_state = DONE;
         end
         LOAD:    next_state = DRAW;
         DRAW:    if (last_pix) next_state = FLUSH;
         FLUSH:   next_state = last_slot ? DONE : SCAN;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Slot walker, object latch, pixel pipeline and drawn-object count.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         slot       <= '0;
         x_q        <= '0;
         y_q        <= '0;
         kind_q     <= '0;
         px         <= '0;
         py         <= '0;
         p_valid    <= 1'b0;
         objs_drawn <= '0;
      end else begin
         p_valid <= (state == DRAW);
         case (state)
            IDLE: begin
               if (start) begin
                  slot       <= '0;
                  objs_drawn <= '0;
               end
            end
            SCAN: begin
               if (!obj_valid[slot] && !last_slot) slot <= slot + SLOT_W'(1);
            end
            LOAD: begin
               x_q    <= obj_x[slot*X_W +: X_W];
               y_q    <= obj_y[slot*Y_W +: Y_W];
               kind_q <= obj_kind[slot*KIND_W +: KIND_W];
            end
            DRAW: begin
               px <= {1'b0, x_q} + (X_W + 1)'(col);
               py <= {1'b0, y_q} + (Y_W + 1)'(row);
            end
            FLUSH: begin
               objs_drawn <= objs_drawn + CNT_W'(1);
               if (!last_slot) slot <= slot + SLOT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // The ROM registers this address, so its data lines up with px/py next cycle.
   assign rom_addr   = {kind_q, row, col};
   assign vga_x      = px[X_W-1:0];
   assign vga_y      = py[Y_W-1:0];
   assign vga_colour = p_valid ? rom_data : '0;
   assign vga_write  = p_valid && (px < X_LIM) && (py < Y_LIM) &&
                       !(TRANSP_EN && (rom_data == TRANSP_COLOR));

endmodule

// File: tb/tb_sprite_batch_draw_engine.sv
// Scoreboard bench: a slot-table reference model queues expected writes,
// a negedge monitor pops and compares every pixel the engine writes.
module tb_sprite_batch_draw_engine;
   import draw_pkg::*;

   localparam int N     = 8;
   localparam int XW    = 9;
   localparam int YW    = 8;
   localparam int KW    = 2;
   localparam int CW    = 3;
   localparam int LIMIT = 5000;

   typedef struct {
      int x;
      int y;
      int c;
   } pix_t;

   logic              clk;
   logic              resetn;
   logic              start;
   logic [N-1:0]      obj_valid;
   logic [N*XW-1:0]   obj_x;
   logic [N*YW-1:0]   obj_y;
   logic [N*KW-1:0]   obj_kind;
   logic [ROM_AW-1:0] rom_addr;
   logic [CW-1:0]     rom_data;
   logic [XW-1:0]     vga_x;
   logic [YW-1:0]     vga_y;
   logic [CW-1:0]     vga_colour;
   logic              vga_write;
   logic              busy;
   logic              done;
   logic [3:0]        objs_drawn;

   logic [CW-1:0] rom_img [0:(1<<ROM_AW)-1];

   int   checks;
   int   failures;
   int   writes;
   pix_t exp_q[$];
   pix_t mon_e;

   sprite_batch_draw_engine dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .obj_valid  (obj_valid),
      .obj_x      (obj_x),
      .obj_y      (obj_y),
      .obj_kind   (obj_kind),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_write  (vga_write),
      .busy       (busy),
      .done       (done),
      .objs_drawn (objs_drawn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous sprite ROM.
   always @(posedge clk) rom_data <= rom_img[rom_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every write must match the head of the expected queue.
   always @(negedge clk) begin
      if (resetn && vga_write) begin
         writes++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got x=%0d y=%0d c=%0d expected no write",
                     vga_x, vga_y, vga_colour);
         end else begin
            mon_e = exp_q.pop_front();
            check("pix_x", 32'(vga_x), mon_e.x);
            check("pix_y", 32'(vga_y), mon_e.y);
            check("pix_c", 32'(vga_colour), mon_e.c);
         end
      end
   end

   task automatic set_slot(input int i, input bit v, input int x, input int y, input int k);
      obj_valid[i]         = v;
      obj_x[i*XW +: XW]    = XW'(x);
      obj_y[i*YW +: YW]    = YW'(y);
      obj_kind[i*KW +: KW] = KW'(k);
   endtask

   // Reference model: walk the table and each sprite in raster order.
   task automatic build_model(output int n_obj);
      pix_t p;
      int   x, y, k;
      n_obj = 0;
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
         if (obj_valid[i]) begin
            n_obj++;
            x = int'(obj_x[i*XW +: XW]);
            y = int'(obj_y[i*YW +: YW]);
            k = int'(obj_kind[i*KW +: KW]);
            for (int r = 0; r < 16; r++) begin
               for (int c = 0; c < 16; c++) begin
                  p.x = x + c;
                  p.y = y + r;
                  p.c = int'(rom_img[k*256 + r*16 + c]);
                  if (p.x < 320 && p.y < 240 && p.c != 0) exp_q.push_back(p);
               end
            end
         end
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_busy"},   32'(busy), 0);
      check({tag, "_done"},   32'(done), 0);
      check({tag, "_write"},  32'(vga_write), 0);
      check({tag, "_addr"},   32'(rom_addr), 0);
      check({tag, "_x"},      32'(vga_x), 0);
      check({tag, "_y"},      32'(vga_y), 0);
      check({tag, "_colour"}, 32'(vga_colour), 0);
      check({tag, "_objs"},   32'(objs_drawn), 0);
   endtask

   // One batch: model, start pulse, bounded wait for done, then compare totals.
   // mid_cycle > 0 pulses start again and moves slot 3 at that busy cycle.
   task automatic run_batch(input string tag, input int mid_cycle, input int mid_x,
                            output int got_writes);
      int n_obj, exp_cycles, exp_writes, cyc;
      build_model(n_obj);
      exp_cycles = N + n_obj * (SPR_PIX + 2) + 1;
      exp_writes = exp_q.size();
      writes = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      cyc = 1;
      while (done !== 1'b1 && cyc < LIMIT) begin
         @(negedge clk);
         cyc++;
         start = (mid_cycle != 0 && cyc == mid_cycle);
         if (start) obj_x[3*XW +: XW] = XW'(mid_x);
      end
      start = 1'b0;
      check({tag, "_cycles"}, cyc, exp_cycles);
      check({tag, "_objs"}, 32'(objs_drawn), n_obj);
      check({tag, "_writes"}, writes, exp_writes);
      check({tag, "_left"}, exp_q.size(), 0);
      got_writes = writes;
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 0);
      check({tag, "_idle"}, 32'(busy), 0);
      check({tag, "_objs_held"}, 32'(objs_drawn), n_obj);
   endtask

   initial begin
      int w;
      int cyc;
      int nob;

      checks = 0;
      failures = 0;
      writes = 0;
      start = 1'b0;
      obj_valid = '0;
      obj_x = '0;
      obj_y = '0;
      obj_kind = '0;

      // ROM: kind0 checkerboard with transparent squares, kinds 1/2 opaque, kind3 random.
      for (int k = 0; k < 4; k++) begin
         for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
               case (k)
                  0:       rom_img[k*256 + r*16 + c] = ((r + c) % 2 == 1) ? 3'd0 : 3'd5;
                  3:       rom_img[k*256 + r*16 + c] = CW'($urandom_range(0, 7));
                  default: rom_img[k*256 + r*16 + c] = CW'(1 + (r*3 + c + k) % 7);
               endcase
            end
         end
      end

      resetn = 1'b0;
      #12;
      check_idle_zero("reset");
      @(negedge clk) resetn = 1'b1;

      // Empty table.
      run_batch("empty", 0, 0, w);
      check("empty_cycles_abs", writes, 0);

      // Two objects in slots 0 and 2.
      set_slot(0, 1, 10, 20, 1);
      set_slot(2, 1, 100, 50, 2);
      run_batch("two", 0, 0, w);
      check("two_writes_abs", w, 512);

      // Bottom-right corner: only the 8x8 on-screen quarter is written.
      obj_valid = '0;
      set_slot(0, 1, 312, 232, 1);
      run_batch("corner", 0, 0, w);
      check("corner_writes_abs", w, 64);

      // Checkerboard with transparent key.
      obj_valid = '0;
      set_slot(5, 1, 40, 40, 0);
      run_batch("transp", 0, 0, w);
      check("transp_writes_abs", w, 128);

      // Reset during DRAW pixel 100 of slot 1.
      obj_valid = '0;
      set_slot(1, 1, 50, 60, 1);
      build_model(nob);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      cyc = 1;
      while (cyc < 104) begin
         @(negedge clk);
         cyc++;
      end
      resetn = 1'b0;
      #1;
      check_idle_zero("midreset");
      exp_q.delete();
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      writes = 0;
      repeat (10) @(negedge clk);
      check("midreset_no_writes", writes, 0);
      check("midreset_idle", 32'(busy), 0);
      run_batch("after_reset", 0, 0, w);

      // Start pulse and slot x change while slot 3 is being drawn.
      obj_valid = '0;
      set_slot(3, 1, 200, 100, 2);
      run_batch("midchange", 4 + 1 + 50, 7, w);

      // Random tables, including clipped and wrapping coordinates.
      for (int b = 0; b < 5; b++) begin
         for (int i = 0; i < N; i++) begin
            set_slot(i, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(300, 511) : $urandom_range(0, 319),
                     $urandom_range(0, 255), $urandom_range(0, 3));
         end
         run_batch($sformatf("rand%0d", b), 0, 0, w);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
